// File: rtl/filter_pkg.sv
// filter_pkg: shared sizing helpers and filt_sel clamp for the moving-average filter
package filter_pkg;
  localparam int BIT_WIDTH_DEF = 16;
  localparam int MAX_LOG2_DEF  = 5;
  localparam int SEL_WIDTH_DEF = 3;
  function automatic int max_taps(input int max_log2);
    return 1 << max_log2;
  endfunction
  function automatic int acc_width(input int bit_width, input int max_log2);
    return bit_width + max_log2;
  endfunction
  function automatic int sel_width(input int max_log2);
    return $clog2(max_log2 + 1);
  endfunction
  function automatic int clamp_sel(input int sel, input int max_log2);
    return (sel > max_log2) ? max_log2 : sel;
  endfunction
endpackage

// File: rtl/round_shift.sv
// round_shift: round-half-up arithmetic right shift of the running sum by k
module round_shift #(
  parameter int ACC_WIDTH = 21,
  parameter int BIT_WIDTH = 16,
  parameter int K_WIDTH   = 3
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [K_WIDTH-1:0]   k,
  output logic signed [BIT_WIDTH-1:0] q
);
  logic signed [ACC_WIDTH-1:0] half;
  assign half = (k == '0) ? '0 : ACC_WIDTH'(1) << (k - K_WIDTH'(1));
  assign q = BIT_WIDTH'((acc + half) >>> k);
endmodule

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: run-time selectable 2^k boxcar average over signed samples,
// running-sum accumulator, two-stage valid pipeline, priming flag and window-change flush.
module moving_avg_filter
  import filter_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int MAX_LOG2  = MAX_LOG2_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sclr,
  input  logic [SEL_WIDTH-1:0]                filt_sel,
  input  logic                                in_valid,
  input  logic signed [BIT_WIDTH-1:0]         d,
  output logic                                out_valid,
  output logic signed [BIT_WIDTH-1:0]         q,
  output logic                                out_primed,
  output logic [sel_width(MAX_LOG2)-1:0]      active_sel
);
  localparam int TAPS = max_taps(MAX_LOG2);
  localparam int AW   = acc_width(BIT_WIDTH, MAX_LOG2);
  localparam int SW   = sel_width(MAX_LOG2);
  localparam int FW   = MAX_LOG2 + 1;
  logic signed [BIT_WIDTH-1:0] hist_q [TAPS];
  logic signed [BIT_WIDTH-1:0] hist_d [TAPS];
  logic signed [AW-1:0]        acc_q, acc_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [SW-1:0]               active_sel_q, active_sel_d, k1_q, k1_d, sel_c;
  logic                        v1_q, v1_d, p1_q, p1_d;
  logic                        out_valid_q, out_valid_d, out_primed_q, out_primed_d;
  logic signed [BIT_WIDTH-1:0] q_q, q_d, x_old, rs_q;
  logic [MAX_LOG2-1:0]         tap;
  logic                        chg, accept, v2;
  assign sel_c  = SW'(clamp_sel(int'(filt_sel), MAX_LOG2));
  assign tap    = MAX_LOG2'((1 << active_sel_q) - 1);
  assign x_old  = hist_q[tap];
  assign chg    = sclr || (sel_c != active_sel_q);
  assign accept = in_valid && !sclr;
  assign v2     = v1_q && !sclr;
  round_shift #(.ACC_WIDTH(AW), .BIT_WIDTH(BIT_WIDTH), .K_WIDTH(SW)) u_round (
    .acc(acc_q),
    .k  (k1_q),
    .q  (rs_q)
  );
  always_comb begin
    hist_d       = hist_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    active_sel_d = active_sel_q;
    v1_d         = 1'b0;
    k1_d         = k1_q;
    p1_d         = p1_q;
    out_valid_d  = v2;
    q_d          = v2 ? rs_q : q_q;
    out_primed_d = v2 ? p1_q : out_primed_q;
    if (chg) begin
      for (int i = 0; i < TAPS; i++) hist_d[i] = '0;
      acc_d        = '0;
      fill_d       = '0;
      active_sel_d = sel_c;
    end
    // a sample coinciding with a window change seeds the fresh history
    if (accept) begin
      hist_d[0] = d;
      for (int i = 1; i < TAPS; i++) hist_d[i] = chg ? '0 : hist_q[i-1];
      acc_d  = chg ? AW'(d) : acc_q + AW'(d) - AW'(x_old);
      fill_d = chg ? FW'(1) : (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);
      v1_d   = 1'b1;
      k1_d   = active_sel_d;
      p1_d   = fill_d >= (FW'(1) << active_sel_d);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
      acc_q        <= '0;
      fill_q       <= '0;
      active_sel_q <= '0;
      v1_q         <= 1'b0;
      k1_q         <= '0;
      p1_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      q_q          <= '0;
      out_primed_q <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      active_sel_q <= active_sel_d;
      v1_q         <= v1_d;
      k1_q         <= k1_d;
      p1_q         <= p1_d;
      out_valid_q  <= out_valid_d;
      q_q          <= q_d;
      out_primed_q <= out_primed_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign q          = q_q;
  assign out_primed = out_primed_q;
  assign active_sel = active_sel_q;
endmodule

// File: tb/tb_moving_avg_filter.sv
// tb_moving_avg_filter: directed vectors with a scoreboard queue; a monitor pops and
// compares whenever out_valid is seen.
module tb_moving_avg_filter;
  typedef struct {
    logic signed [15:0] q;
    logic               p;
    string              name;
  } exp_t;
  logic               clk = 1'b0;
  logic               rst_n, sclr, in_valid, out_valid, out_primed;
  logic [2:0]         filt_sel, active_sel;
  logic signed [15:0] d, q;
  exp_t               sb[$];
  int                 vectors = 0;
  int                 misc = 0;
  moving_avg_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclr      (sclr),
    .filt_sel  (filt_sel),
    .in_valid  (in_valid),
    .d         (d),
    .out_valid (out_valid),
    .q         (q),
    .out_primed(out_primed),
    .active_sel(active_sel)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        misc++;
        $display("FAIL unexpected_out q=%0d primed=%0b required no output", q, out_primed);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (q !== e.q || out_primed !== e.p) begin
          misc++;
          $display("FAIL %s q=%0d primed=%0b required q=%0d primed=%0b", e.name, q, out_primed, e.q, e.p);
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int v);
    in_valid = 1'b1;
    d = 16'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic push(input int eq, input logic ep, input string name);
    exp_t e;
    e.q = 16'(eq);
    e.p = ep;
    e.name = name;
    sb.push_back(e);
  endtask
  task automatic sendx(input int v, input int eq, input logic ep, input string name);
    push(eq, ep, name);
    send(v);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      misc++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask
  function automatic int fdiv(input longint a, input longint b);
    return (a >= 0) ? int'(a / b) : int'(-((-a + b - 1) / b));
  endfunction
  initial begin
    rst_n = 1'b0; sclr = 1'b0; in_valid = 1'b0; d = '0; filt_sel = 3'd0;
    idle(2);
    chk("rst_q", int'(q), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_primed", int'(out_primed), 0);
    chk("rst_active_sel", int'(active_sel), 0);
    rst_n = 1'b1;
    idle(1);
    filt_sel = 3'd2;
    idle(1);
    chk("k2_active_sel", int'(active_sel), 2);
    sendx(4, 1, 0, "k2_s1"); sendx(8, 3, 0, "k2_s2"); sendx(12, 6, 0, "k2_s3");
    sendx(16, 10, 1, "k2_s4"); sendx(20, 14, 1, "k2_s5");
    drain();
    filt_sel = 3'd1;
    idle(1);
    sendx(-3, -1, 0, "k1_neg1"); sendx(-4, -3, 1, "k1_neg2");
    drain();
    filt_sel = 3'd7;
    idle(1);
    chk("clamp_active_sel", int'(active_sel), 5);
    for (int j = 1; j <= 32; j++) sendx(32767, fdiv(longint'(j) * 32767 + 16, 32), j == 32, "k5_max");
    filt_sel = 3'd5;
    for (int j = 1; j <= 32; j++)
      sendx(-32768, fdiv(longint'(32 - j) * 32767 - longint'(j) * 32768 + 16, 32), 1, "k5_min");
    drain();
    chk("k5_final_q", int'(q), -32768);
    chk("k5_active_sel", int'(active_sel), 5);
    filt_sel = 3'd2;
    idle(1);
    sendx(100, 25, 0, "wc_a"); sendx(100, 50, 0, "wc_b"); sendx(100, 75, 0, "wc_c");
    sendx(100, 100, 1, "wc_d");
    filt_sel = 3'd0;
    sendx(40, 40, 1, "wc_new_k0");
    chk("wc_active_sel", int'(active_sel), 0);
    drain();
    filt_sel = 3'd2;
    idle(1);
    send(5);
    sclr = 1'b1; in_valid = 1'b1; d = 16'sd6;
    idle(1);
    sclr = 1'b0; in_valid = 1'b0;
    idle(3);
    sendx(8, 2, 0, "sclr_after");
    drain();
    sclr = 1'b1;
    idle(1);
    sclr = 1'b0;
    foreach (sb[i]) ;
    sendx(4, 1, 0, "gap_s1"); idle(2); sendx(8, 3, 0, "gap_s2"); idle(2);
    sendx(12, 6, 0, "gap_s3"); idle(2); sendx(16, 10, 1, "gap_s4"); idle(2);
    sendx(20, 14, 1, "gap_s5");
    drain();
    send(4);
    rst_n = 1'b0;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_primed", int'(out_primed), 0);
    chk("arst_active_sel", int'(active_sel), 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    sendx(8, 2, 0, "post_rst_fill1");
    drain();
    idle(4);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
